stack_unit: RTL
===============

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 16: number of stack entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 push  input  1  write din onto the stack this cycle.
REQ-006 pop  input  1  remove the top entry this cycle.
REQ-007 tos  input  1  capture the current top entry into dout.
REQ-008 clr_err  input  1  clear the sticky error flags.
REQ-009 din  input  WIDTH  data to push.
REQ-010 dout  output  WIDTH  registered top-of-stack read result.
REQ-011 dout_valid  output  1  one-cycle pulse marking an updated dout.
REQ-012 count  output  log2(DEPTH)+1  number of valid entries.
REQ-013 empty  output  1  high when count==0; combinational from count.
REQ-014 full  output  1  high when count==DEPTH; combinational from count.
REQ-015 overflow  output  1  sticky flag: a push was rejected.
REQ-016 underflow  output  1  sticky flag: a pop or tos found the stack empty.

Function
REQ-017 Storage: DEPTH x WIDTH register array, indexed by count; top entry at index count-1.
REQ-018 Push only, not full:
- mem[count] <= din
- count increments
REQ-019 Push only, full:
- storage and count unchanged
- overflow <= 1
REQ-020 Pop only, not empty: count decrements; array contents unchanged.
REQ-021 Pop only, empty:
- count unchanged
- underflow <= 1
REQ-022 Push and pop together, count>=1 (including full):
- top entry overwritten with din
- count unchanged
- no flag set
REQ-023 Push and pop together, empty: behaves as a plain push (count becomes 1); no flag set.
REQ-024 Tos, not empty:
- dout <= top entry as it was before this edge
- dout_valid pulses high the next cycle
- read latency: one cycle
REQ-025 Tos, empty:
- dout <= 0
- dout_valid pulses
- underflow <= 1
REQ-026 Tos with pop, push, or both in the same cycle: dout captures the pre-edge top; the stack update (REQ-018..023) happens on the same edge.
REQ-027 dout holds its value between tos requests; dout_valid is low in every cycle not following a tos.
REQ-028 clr_err clears overflow and underflow on the next edge; if an error condition occurs in the same cycle, the flag is set (set wins).
REQ-029 count never exceeds DEPTH and never wraps below 0.

Reset
REQ-030 Asserting rst low immediately forces, regardless of clk:
- count=0, so empty=1 and full=0
- dout=0
- dout_valid=0
- overflow=0
- underflow=0
REQ-031 Array contents need not be reset; they are unobservable while count==0.
REQ-032 Reset asserted mid-operation discards any in-flight push or pop in that cycle.
REQ-033 Operation resumes on the first rising clk edge after rst returns high.

Verification
REQ-034 Push 0x11, 0x22, 0x33, then tos -> next cycle: dout=0x33, dout_valid=1, count=3.
REQ-035 Push 16 values, then push 0xAA -> full=1, count=16, overflow=1; a following tos returns the 16th value, not 0xAA.
REQ-036 From reset, pop -> underflow=1, count=0. Then clr_err -> underflow=0. Then tos -> dout=0, underflow=1.
REQ-037 Stack holds 0x05, 0x07; assert push=1, pop=1, din=0x09, tos=1 in one cycle:
- dout=0x07
- count stays 2
- the next tos returns 0x09
REQ-038 Push 3 values, drop rst low between clock edges -> all outputs take their reset values at once; after release, a pop sets underflow.
REQ-039 Pop with clr_err=1 on an empty stack with underflow=1 -> underflow stays 1 (set wins).

Source files
------------

// File: rtl/stack_unit_if.sv
// Bundles the stack command/data bus; master drives commands, slave returns status and read data.
interface stack_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic             tos;
    logic             clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, tos, clr_err, din,
        input  dout, dout_valid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, tos, clr_err, din,
        output dout, dout_valid, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_unit.sv
// LIFO register stack with registered top-of-stack read (1-cycle latency) and sticky error flags.
// No backpressure: pushes when full and pops/reads when empty are dropped and flagged instead.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    stack_unit_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    cnt_nxt;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    mem_addr;
    logic             mem_we;
    logic             empty;
    logic             full;
    logic             ovf_set;
    logic             unf_set;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             overflow;
    logic             underflow;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Push+pop on a non-empty stack replaces the top in place; on an empty stack it is a plain push.
    always_comb begin
        top_idx  = AW'(count - CW'(1));
        mem_we   = 1'b0;
        mem_addr = count[AW-1:0];
        cnt_nxt  = count;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (bus.push && bus.pop && !empty) begin
            mem_we   = 1'b1;
            mem_addr = top_idx;
        end else if (bus.push) begin
            if (!full) begin
                mem_we  = 1'b1;
                cnt_nxt = count + CW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (bus.pop) begin
            if (!empty) cnt_nxt = count - CW'(1);
            else        unf_set = 1'b1;
        end
        if (bus.tos && empty) unf_set = 1'b1;
    end

    // Storage is not reset; entries at or above count are never observed.
    always_ff @(posedge clk) begin
        if (rst && mem_we) mem[mem_addr] <= bus.din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= cnt_nxt;
            dout_valid <= bus.tos;
            if (bus.tos) dout <= empty ? '0 : mem[top_idx];
            overflow   <= ovf_set | (overflow  & ~bus.clr_err);
            underflow  <= unf_set | (underflow & ~bus.clr_err);
        end
    end

    assign bus.dout       = dout;
    assign bus.dout_valid = dout_valid;
    assign bus.count      = count;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.overflow   = overflow;
    assign bus.underflow  = underflow;
endmodule
